// File: rtl/inst_fetch_pkg.sv
// Shared constants and helpers for the IF stage.
// IFU_ADEL_EN selects the fetch address-error logic in inst_fetch.
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_BASE        = 32'h0000_3000;
    localparam int          IM_WORDS       = 4096;
    localparam logic [31:0] IM_LAST        = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;
    localparam logic [4:0]  EXC_ADEL       = 5'd4;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_REDIRECT,
        NPC_HOLD,
        NPC_ERET,
        NPC_EXC
    } npc_sel_e;

    // A fetch is bad when misaligned or outside the ROM window.
    function automatic logic pc_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
    endfunction

endpackage

// File: rtl/inst_fetch_npc.sv
// Next-PC select for the IF stage.
// Priority: exception > eret > stall > redirect > sequential.
module inst_fetch_npc
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic [31:0] pc_f,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] npc
);

    npc_sel_e sel;

    always_comb begin
        sel = NPC_SEQ;
        if (exc_req)       sel = NPC_EXC;
        else if (eret)     sel = NPC_ERET;
        else if (stall)    sel = NPC_HOLD;
        else if (redirect) sel = NPC_REDIRECT;
    end

    always_comb begin
        npc = pc_f + 32'd4;
        case (sel)
            NPC_EXC:      npc = HANDLER_PC;
            NPC_ERET:     npc = epc;
            NPC_HOLD:     npc = pc_f;
            NPC_REDIRECT: npc = redirect_pc;
            default:      npc = pc_f + 32'd4;
        endcase
    end

endmodule

// File: rtl/inst_fetch.sv
// IF stage: PC register, ROM address drive and IF/ID pipeline register.
// Define IFU_ADEL_EN to build misaligned/out-of-range fetch detection (adel_d).
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        branch_d,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] pc_f,
    output logic [31:0] inst_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic        bd_d,
    output logic        adel_d
);

    logic [31:0] npc;
    logic [31:0] if_word;
    logic        flush;

    assign imem_addr = pc_f;
    assign flush     = exc_req | eret;

    inst_fetch_npc #(
        .HANDLER_PC (HANDLER_PC)
    ) u_npc (
        .pc_f        (pc_f),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .npc         (npc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) pc_f <= RESET_PC;
        else          pc_f <= npc;
    end

`ifdef IFU_ADEL_EN
    logic fetch_fault;
    logic adel_q;

    assign fetch_fault = pc_fault(pc_f);
    assign if_word     = fetch_fault ? 32'd0 : imem_inst;
    assign adel_d      = adel_q;

    always_ff @(posedge clk) begin
        if (!reset_n)    adel_q <= 1'b0;
        else if (flush)  adel_q <= 1'b0;
        else if (!stall) adel_q <= fetch_fault;
    end
`else
    assign if_word = imem_inst;
    assign adel_d  = 1'b0;
`endif

    // Flush wins over stall so exception entry never leaves a stale slot in ID.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inst_d  <= 32'd0;
            pc_d    <= 32'd0;
            valid_d <= 1'b0;
            bd_d    <= 1'b0;
        end else if (flush) begin
            inst_d  <= 32'd0;
            valid_d <= 1'b0;
            bd_d    <= 1'b0;
        end else if (!stall) begin
            inst_d  <= if_word;
            pc_d    <= pc_f;
            valid_d <= 1'b1;
            bd_d    <= branch_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, redirect, branch_d, exc_req, eret;
    logic [31:0] redirect_pc, epc;
    logic [31:0] imem_addr, imem_inst, pc_f, inst_d, pc_d;
    logic        valid_d, bd_d, adel_d;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    assign imem_inst = rom(imem_addr);

    inst_fetch dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .branch_d(branch_d), .exc_req(exc_req),
        .eret(eret), .epc(epc), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .pc_f(pc_f), .inst_d(inst_d), .pc_d(pc_d), .valid_d(valid_d),
        .bd_d(bd_d), .adel_d(adel_d)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the architectural state.
    logic [31:0] m_pc, m_inst, m_pcd;
    logic        m_valid, m_bd, m_adel, m_live = 1'b0;

    function automatic logic m_fault(input logic [31:0] a);
`ifdef IFU_ADEL_EN
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        logic [31:0] nxt;
        if (!reset_n) begin
            m_pc = 32'h3000; m_inst = 0; m_pcd = 0;
            m_valid = 0; m_bd = 0; m_adel = 0; m_live = 1'b1;
        end else begin
            if (exc_req)       nxt = 32'h4180;
            else if (eret)     nxt = epc;
            else if (stall)    nxt = m_pc;
            else if (redirect) nxt = redirect_pc;
            else               nxt = m_pc + 4;
            if (exc_req || eret) begin
                m_inst = 0; m_valid = 0; m_bd = 0; m_adel = 0;
            end else if (!stall) begin
                m_adel  = m_fault(m_pc);
                m_inst  = m_adel ? 32'd0 : rom(m_pc);
                m_pcd   = m_pc;
                m_valid = 1;
                m_bd    = branch_d;
            end
            m_pc = nxt;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model.pc_f",      pc_f,      m_pc);
            chk("model.imem_addr", imem_addr, m_pc);
            chk("model.inst_d",    inst_d,    m_inst);
            chk("model.pc_d",      pc_d,      m_pcd);
            chk("model.valid_d",   32'(valid_d), 32'(m_valid));
            chk("model.bd_d",      32'(bd_d),    32'(m_bd));
            chk("model.adel_d",    32'(adel_d),  32'(m_adel));
        end
    end

    task automatic idle();
        stall = 0; redirect = 0; branch_d = 0; exc_req = 0; eret = 0;
        redirect_pc = 0; epc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        idle();
        reset_n = 0;
        repeat (n) step();
        reset_n = 1;
    endtask

    initial begin
        idle();
        reset_n = 0;
        // 1: reset and first fetch
        do_reset(2);
        chk("rst.pc_f",    pc_f, 32'h3000);
        chk("rst.valid_d", 32'(valid_d), 0);
        chk("rst.pc_d",    pc_d, 0);
        chk("rst.inst_d",  inst_d, 0);
        chk("rst.adel_d",  32'(adel_d), 0);
        step();
        chk("first.pc_d",    pc_d, 32'h3000);
        chk("first.valid_d", 32'(valid_d), 1);
        chk("first.inst_d",  inst_d, rom(32'h3000));
        // 2: free run
        step(); step();
        chk("run.pc_f",   pc_f, 32'h300C);
        chk("run.pc_d",   pc_d, 32'h3008);
        chk("run.inst_d", inst_d, rom(32'h3008));

        // 3: stall holds PC and IF/ID
        do_reset(1);
        step(); step();
        chk("pre_stall.pc_f", pc_f, 32'h3008);
        stall = 1;
        step(); step();
        chk("stall.pc_f",   pc_f, 32'h3008);
        chk("stall.pc_d",   pc_d, 32'h3004);
        chk("stall.inst_d", inst_d, rom(32'h3004));
        stall = 0;
        step();
        chk("unstall.pc_f", pc_f, 32'h300C);
        chk("unstall.pc_d", pc_d, 32'h3008);

        // 4: redirect with delay slot
        do_reset(1);
        step();
        redirect = 1; redirect_pc = 32'h3040; branch_d = 1;
        step();
        chk("br.pc_f", pc_f, 32'h3040);
        chk("br.pc_d", pc_d, 32'h3004);
        chk("br.bd_d", 32'(bd_d), 1);
        idle();
        step();
        chk("tgt.pc_d", pc_d, 32'h3040);
        chk("tgt.bd_d", 32'(bd_d), 0);

        // 5: exception beats stall, eret flushes
        exc_req = 1; stall = 1;
        step();
        chk("exc.pc_f",    pc_f, 32'h4180);
        chk("exc.valid_d", 32'(valid_d), 0);
        chk("exc.inst_d",  inst_d, 0);
        idle();
        step();
        chk("hdl.pc_d", pc_d, 32'h4180);
        eret = 1; epc = 32'h3010; redirect = 1; redirect_pc = 32'h5000;
        step();
        chk("eret.pc_f",    pc_f, 32'h3010);
        chk("eret.valid_d", 32'(valid_d), 0);
        chk("eret.bd_d",    32'(bd_d), 0);
        idle();

        // redirect under stall is dropped
        redirect = 1; redirect_pc = 32'h3100; stall = 1;
        step();
        chk("rd_stall.pc_f", pc_f, 32'h3010);
        idle();

        // PC wrap
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        step();
        idle();
        step();
        chk("wrap.pc_f", pc_f, 32'h0000_0000);

`ifdef IFU_ADEL_EN
        // 6: address errors
        redirect = 1; redirect_pc = 32'h3002;
        step(); idle(); step();
        chk("adel_mis.adel_d", 32'(adel_d), 1);
        chk("adel_mis.inst_d", inst_d, 0);
        chk("adel_mis.pc_d",   pc_d, 32'h3002);
        chk("adel_mis.valid",  32'(valid_d), 1);
        redirect = 1; redirect_pc = 32'h7000;
        step(); idle(); step();
        chk("adel_hi.adel_d", 32'(adel_d), 1);
        redirect = 1; redirect_pc = 32'h6FFC;
        step(); idle(); step();
        chk("last.adel_d", 32'(adel_d), 0);
        chk("last.inst_d", inst_d, rom(32'h6FFC));
`endif

        // Randomized traffic, checked by the compare process.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset_n     = ($urandom_range(0, 99) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 4) == 0);
            branch_d    = ($urandom_range(0, 3) == 0);
            exc_req     = ($urandom_range(0, 29) == 0);
            eret        = ($urandom_range(0, 29) == 0);
`ifdef IFU_ADEL_EN
            redirect_pc = ($urandom_range(0, 5) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(0, 4000);
            epc         = ($urandom_range(0, 5) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(0, 4000);
`else
            redirect_pc = 32'h3000 + 4 * $urandom_range(0, 4000);
            epc         = 32'h3000 + 4 * $urandom_range(0, 4000);
`endif
        end
        @(negedge clk);
        idle();
        reset_n = 1;
        step();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
